// File: rtl/jk_ff.sv
// jk_ff
// -----------------------------------------------------------------------------
// Bank of WIDTH independent clocked JK flip-flops sharing one clock and one
// synchronous, active-high reset. Each bit holds, clears, sets or toggles on
// every rising edge of clk according to its own j/k pair. Reset has priority
// and loads RESET_VALUE. qbar is the combinational complement of the single
// state register, so q and qbar can never disagree.
//
// Parameters:
//   WIDTH       - number of independent JK cells (default 1)
//   RESET_VALUE - value loaded into q on reset (default all zeros)
//
// Ports:
//   clk   in  1      clock, rising edge active
//   reset in  1      synchronous active-high reset
//   j     in  WIDTH  per-bit J (set) input
//   k     in  WIDTH  per-bit K (clear) input
//   q     out WIDTH  registered state
//   qbar  out WIDTH  bitwise complement of q
// -----------------------------------------------------------------------------
module jk_ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  // Per-bit characteristic equation: Q+ = J & ~Q | ~K & Q.
  // Covers hold (00), clear (01), set (10) and toggle (11) in one expression.
  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      assign w_q_next[gi] = (j[gi] & ~r_q[gi]) | (~k[gi] & r_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q    = r_q;
  // Derived from the same register so there is no extra latency and no way
  // for the complement to drift from q.
  assign qbar = ~r_q;

endmodule

// File: tb/tb_jk_ff.sv
module tb_jk_ff;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [0:0] j1, k1, q1, qb1;
  logic [3:0] j4, k4, q4, qb4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_ff u_dut1 (
    .clk  (clk),
    .reset(rst1),
    .j    (j1),
    .k    (k1),
    .q    (q1),
    .qbar (qb1)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut4 (
    .clk  (clk),
    .reset(rst4),
    .j    (j4),
    .k    (k4),
    .q    (q4),
    .qbar (qb4)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       j;
    logic       k;
    logic       exp_q;
  } vec_t;

  vec_t vecs[$];

  // Reference: per-bit truth table of the JK cell, reset wins.
  function automatic logic [3:0] jk_model(input logic [3:0] prev, input logic [3:0] j,
                                          input logic [3:0] k, input logic rst,
                                          input logic [3:0] rv);
    logic [3:0] n;
    if (rst) return rv;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00:   n[i] = prev[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = (prev[i] == 1'b1) ? 1'b0 : 1'b1;
      endcase
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end else begin
      $display("ok   %s: q=%b", name, got);
    end
  endtask

  task automatic edge_then_sample;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] m1, m4, rj, rk;
    logic       rr;

    rst1 = 1'b1; j1 = '0; k1 = '0;
    rst4 = 1'b1; j4 = '0; k4 = '0;

    // Width-1 directed table (dut4 held in reset meanwhile).
    vecs.push_back('{"reset",          1, 0, 0, 0});
    vecs.push_back('{"reset_over_tog", 1, 1, 1, 0});
    vecs.push_back('{"set",            0, 1, 0, 1});
    vecs.push_back('{"hold1_a",        0, 0, 0, 1});
    vecs.push_back('{"hold1_b",        0, 0, 0, 1});
    vecs.push_back('{"hold1_c",        0, 0, 0, 1});
    vecs.push_back('{"clear",          0, 0, 1, 0});
    vecs.push_back('{"hold0",          0, 0, 0, 0});
    vecs.push_back('{"tog1",           0, 1, 1, 1});
    vecs.push_back('{"tog2",           0, 1, 1, 0});
    vecs.push_back('{"tog3",           0, 1, 1, 1});
    vecs.push_back('{"tog4",           0, 1, 1, 0});
    vecs.push_back('{"tog5",           0, 1, 1, 1});
    vecs.push_back('{"reset_mid_tog",  1, 1, 1, 0});
    vecs.push_back('{"tog_after_rst",  0, 1, 1, 1});
    vecs.push_back('{"tog_after_rst2", 0, 1, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst1 = vecs[i].rst; j1 = vecs[i].j; k1 = vecs[i].k;
      edge_then_sample();
      check({vecs[i].name, ".q"},    {3'b0, q1},  {3'b0, vecs[i].exp_q});
      check({vecs[i].name, ".qbar"}, {3'b0, qb1}, {3'b0, ~vecs[i].exp_q});
    end

    // Width-4 hand sequence: reset value, mixed per-bit ops, then first-edge
    // toggle after reset deasserts.
    check("w4_reset.q", q4, 4'b1010);
    check("w4_reset.qbar", qb4, 4'b0101);
    @(negedge clk);
    rst4 = 1'b0; j4 = 4'b1100; k4 = 4'b0110;
    edge_then_sample();
    check("w4_mixed.q", q4, 4'b1100);
    check("w4_mixed.qbar", qb4, 4'b0011);
    @(negedge clk);
    rst4 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
    edge_then_sample();
    check("w4_rst_again.q", q4, 4'b1010);
    @(negedge clk);
    rst4 = 1'b0;
    edge_then_sample();
    check("w4_tog_from_rv.q", q4, 4'b0101);
    check("w4_tog_from_rv.qbar", qb4, 4'b1010);

    // Randomized run for both instances against the model.
    m1 = {3'b0, q1};
    m4 = q4;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rr = ($urandom_range(0, 15) == 0);
      rj = 4'($urandom); rk = 4'($urandom);
      rst1 = rr; j1 = rj[0]; k1 = rk[0];
      m1 = jk_model(m1, {3'b0, rj[0]}, {3'b0, rk[0]}, rr, 4'b0000);
      rr = ($urandom_range(0, 15) == 0);
      rj = 4'($urandom); rk = 4'($urandom);
      rst4 = rr; j4 = rj; k4 = rk;
      m4 = jk_model(m4, rj, rk, rr, 4'b1010);
      edge_then_sample();
      check($sformatf("rand1_%0d.q", n), {3'b0, q1}, {3'b0, m1[0]});
      check($sformatf("rand1_%0d.qbar", n), {3'b0, qb1}, {3'b0, ~m1[0]});
      check($sformatf("rand4_%0d.q", n), q4, m4);
      check($sformatf("rand4_%0d.qbar", n), qb4, ~m4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
